// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : RV64 memory-access stage. Issues one valid/ready data-memory
//            transaction per load/store and stalls the pipe until it retires.
// Revision : 1.0
// ============================================================================
module mem_access #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] me_alu_result,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    input  logic [1:0]  me_mem_size,
    input  logic [63:0] me_store_data,
    input  logic        me_advance,
    input  logic        me_flush,
    output logic [63:0] me_mem_data,
    output logic [7:0]  me_mem_byte_enable,
    output logic        stall_req,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic [7:0]  dmem_wmask,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [63:0] dmem_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RSP  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Last count value before saturation: the 2^W-1'th RSP cycle fires.
    localparam logic [TIMEOUT_W-1:0] c_CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [1:0]           r_state;
    logic [63:0]          r_data;
    logic                 r_kill;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_bus_err;

    logic [2:0] w_a;
    logic [7:0] w_mask;
    logic       w_mis_addr;
    logic       w_rw;
    logic       w_misalign;
    logic       w_access;
    logic       w_start;
    logic       w_kill_now;

    assign w_a = me_alu_result[2:0];

    always_comb begin
        w_mask = 8'hFF;
        case (me_mem_size)
            2'd0:    w_mask = 8'h01 << w_a;
            2'd1:    w_mask = 8'h03 << w_a;
            2'd2:    w_mask = 8'h0F << w_a;
            default: w_mask = 8'hFF;
        endcase
    end

    always_comb begin
        w_mis_addr = 1'b0;
        case (me_mem_size)
            2'd0:    w_mis_addr = 1'b0;
            2'd1:    w_mis_addr = w_a[0];
            2'd2:    w_mis_addr = |w_a[1:0];
            default: w_mis_addr = |w_a;
        endcase
    end

    assign w_rw       = me_mem_read | me_mem_write;
    assign w_misalign = w_rw & w_mis_addr;
    assign w_access   = w_rw & ~w_mis_addr;
    assign w_start    = w_access & ~me_flush;
    assign w_kill_now = r_kill | me_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_data    <= 64'd0;
            r_kill    <= 1'b0;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_kill <= 1'b0;
                    r_cnt  <= '0;
                    if (w_start) r_state <= c_REQ;
                end
                c_REQ: begin
                    if (me_flush) r_kill <= 1'b1;
                    if (dmem_req_ready) r_state <= c_RSP;
                end
                c_RSP: begin
                    if (dmem_rsp_valid || r_cnt == c_CNT_LAST) begin
                        r_data    <= dmem_rsp_valid ? dmem_rdata : 64'd0;
                        r_bus_err <= ~dmem_rsp_valid;
                        r_cnt     <= '0;
                        r_kill    <= 1'b0;
                        // A killed access retires straight to IDLE, skipping DONE.
                        r_state   <= w_kill_now ? c_IDLE : c_DONE;
                    end else begin
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                        if (me_flush) r_kill <= 1'b1;
                    end
                end
                default: begin
                    if (me_advance || me_flush) r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign me_mem_data        = r_data;
    assign me_mem_byte_enable = w_mask;
    assign misalign_exc       = w_misalign;
    assign bus_err            = r_bus_err;
    assign dmem_req_valid     = (r_state == c_REQ);
    assign dmem_addr          = {me_alu_result[63:3], 3'b000};
    assign dmem_wen           = me_mem_write;
    assign dmem_wmask         = me_mem_write ? w_mask : 8'h00;
    assign dmem_wdata         = me_store_data << {w_a, 3'b000};

    assign stall_req = ~rst & (((r_state == c_IDLE) & w_start) |
                               (r_state == c_REQ) | (r_state == c_RSP));

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Directed self-checking bench for the mem_access stage.
// Revision : 1.0
// ============================================================================
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [63:0] me_alu_result;
    logic        me_mem_read;
    logic        me_mem_write;
    logic [1:0]  me_mem_size;
    logic [63:0] me_store_data;
    logic        me_advance;
    logic        me_flush;
    logic [63:0] me_mem_data;
    logic [7:0]  me_mem_byte_enable;
    logic        stall_req;
    logic        misalign_exc;
    logic        bus_err;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_wmask;
    logic [63:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rdata;

    int n_pass;
    int n_total;

    mem_access #(.TIMEOUT_W(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .me_alu_result      (me_alu_result),
        .me_mem_read        (me_mem_read),
        .me_mem_write       (me_mem_write),
        .me_mem_size        (me_mem_size),
        .me_store_data      (me_store_data),
        .me_advance         (me_advance),
        .me_flush           (me_flush),
        .me_mem_data        (me_mem_data),
        .me_mem_byte_enable (me_mem_byte_enable),
        .stall_req          (stall_req),
        .misalign_exc       (misalign_exc),
        .bus_err            (bus_err),
        .dmem_req_valid     (dmem_req_valid),
        .dmem_req_ready     (dmem_req_ready),
        .dmem_addr          (dmem_addr),
        .dmem_wen           (dmem_wen),
        .dmem_wmask         (dmem_wmask),
        .dmem_wdata         (dmem_wdata),
        .dmem_rsp_valid     (dmem_rsp_valid),
        .dmem_rdata         (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang want finish");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        me_alu_result  = 64'd0;
        me_mem_read    = 1'b0;
        me_mem_write   = 1'b0;
        me_mem_size    = 2'd0;
        me_store_data  = 64'd0;
        me_advance     = 1'b0;
        me_flush       = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 64'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({dmem_req_valid, stall_req, bus_err} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {dmem_req_valid, stall_req, bus_err});
        else n_pass++;
        n_total++;
        if (me_mem_data !== 64'd0)
            $display("FAIL reset_data: got %h want 0", me_mem_data);
        else n_pass++;
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_byte_enable();
        logic [1:0] sz_t  [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        logic [2:0] lo_t  [7] = '{3'd7, 3'd6, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
        logic [7:0] be_t  [7] = '{8'h80, 8'hC0, 8'hF0, 8'hFF, 8'h06, 8'h3C, 8'hFF};
        logic       mis_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            me_mem_size   = sz_t[i];
            me_alu_result = 64'h8000_0000 + 64'(lo_t[i]);
            me_mem_read   = mis_t[i];
            #1;
            n_total++;
            if ({me_mem_byte_enable, misalign_exc, stall_req} !== {be_t[i], mis_t[i], 1'b0})
                $display("FAIL be_vec%0d: got be=%h mis=%b stall=%b want be=%h mis=%b stall=0",
                         i, me_mem_byte_enable, misalign_exc, stall_req, be_t[i], mis_t[i]);
            else n_pass++;
        end
        me_mem_read = 1'b0;
        cycle();
    endtask

    task automatic test_load_dword();
        me_alu_result  = 64'h8000_1000;
        me_mem_size    = 2'd3;
        me_mem_read    = 1'b1;
        dmem_req_ready = 1'b1;
        #1;
        n_total++;
        if ({stall_req, dmem_req_valid, me_mem_byte_enable} !== {1'b1, 1'b0, 8'hFF})
            $display("FAIL ld_idle: got stall=%b req=%b be=%h want 1 0 ff",
                     stall_req, dmem_req_valid, me_mem_byte_enable);
        else n_pass++;
        cycle();
        n_total++;
        if ({stall_req, dmem_req_valid, dmem_wen, dmem_addr} !== {3'b110, 64'h8000_1000})
            $display("FAIL ld_req: got stall=%b req=%b wen=%b addr=%h want 1 1 0 80001000",
                     stall_req, dmem_req_valid, dmem_wen, dmem_addr);
        else n_pass++;
        cycle();
        n_total++;
        if ({stall_req, dmem_req_valid} !== 2'b10)
            $display("FAIL ld_rsp: got stall=%b req=%b want 1 0", stall_req, dmem_req_valid);
        else n_pass++;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 64'h1122_3344_5566_7788;
        cycle();
        dmem_rsp_valid = 1'b0;
        n_total++;
        if ({stall_req, me_mem_data} !== {1'b0, 64'h1122_3344_5566_7788})
            $display("FAIL ld_done: got stall=%b data=%h want 0 1122334455667788",
                     stall_req, me_mem_data);
        else n_pass++;
        me_advance  = 1'b1;
        me_mem_read = 1'b0;
        cycle();
        me_advance = 1'b0;
    endtask

    task automatic test_store_byte();
        me_alu_result  = 64'h8000_0005;
        me_mem_size    = 2'd0;
        me_mem_write   = 1'b1;
        me_store_data  = 64'hAB;
        dmem_req_ready = 1'b1;
        #1;
        n_total++;
        if ({dmem_addr, dmem_wmask, dmem_wen, stall_req} !== {64'h8000_0000, 8'h20, 1'b1, 1'b1})
            $display("FAIL st_fields: got addr=%h wmask=%h wen=%b stall=%b want 80000000 20 1 1",
                     dmem_addr, dmem_wmask, dmem_wen, stall_req);
        else n_pass++;
        n_total++;
        if (dmem_wdata !== 64'h0000_AB00_0000_0000)
            $display("FAIL st_wdata: got %h want 0000ab0000000000", dmem_wdata);
        else n_pass++;
        cycle();
        n_total++;
        if (dmem_req_valid !== 1'b1)
            $display("FAIL st_req: got %b want 1", dmem_req_valid);
        else n_pass++;
        cycle();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        #1;
        n_total++;
        if (stall_req !== 1'b1)
            $display("FAIL st_rsp_stall: got %b want 1", stall_req);
        else n_pass++;
        cycle();
        dmem_rsp_valid = 1'b0;
        n_total++;
        if (stall_req !== 1'b0)
            $display("FAIL st_done_stall: got %b want 0", stall_req);
        else n_pass++;
        me_advance   = 1'b1;
        me_mem_write = 1'b0;
        cycle();
        me_advance = 1'b0;
    endtask

    task automatic test_misalign();
        me_alu_result  = 64'h8000_0002;
        me_mem_size    = 2'd2;
        me_mem_read    = 1'b1;
        dmem_req_ready = 1'b1;
        #1;
        n_total++;
        if ({misalign_exc, stall_req} !== 2'b10)
            $display("FAIL mis_comb: got mis=%b stall=%b want 1 0", misalign_exc, stall_req);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_total++;
            if ({dmem_req_valid, stall_req} !== 2'b00)
                $display("FAIL mis_noreq%0d: got req=%b stall=%b want 0 0",
                         i, dmem_req_valid, stall_req);
            else n_pass++;
        end
        me_mem_read    = 1'b0;
        dmem_req_ready = 1'b0;
        cycle();
    endtask

    task automatic test_ready_hold();
        me_alu_result = 64'h8000_2008;
        me_mem_size   = 2'd3;
        me_mem_read   = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({dmem_req_valid, dmem_addr} !== {1'b1, 64'h8000_2008})
                $display("FAIL hold_req%0d: got req=%b addr=%h want 1 80002008",
                         i, dmem_req_valid, dmem_addr);
            else n_pass++;
            cycle();
        end
        dmem_req_ready = 1'b1;
        cycle();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 64'hCAFE_F00D_1234_5678;
        cycle();
        dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({stall_req, me_mem_data} !== {1'b0, 64'hCAFE_F00D_1234_5678})
                $display("FAIL hold_done%0d: got stall=%b data=%h want 0 cafef00d12345678",
                         i, stall_req, me_mem_data);
            else n_pass++;
            cycle();
        end
        dmem_rsp_valid = 1'b0;
        me_advance     = 1'b1;
        me_mem_read    = 1'b0;
        cycle();
        me_advance = 1'b0;
        n_total++;
        if ({stall_req, dmem_req_valid} !== 2'b00)
            $display("FAIL hold_exit: got stall=%b req=%b want 0 0", stall_req, dmem_req_valid);
        else n_pass++;
    endtask

    task automatic test_flush_rsp();
        me_alu_result  = 64'h8000_3000;
        me_mem_size    = 2'd3;
        me_mem_read    = 1'b1;
        dmem_req_ready = 1'b1;
        cycle();
        cycle();
        dmem_req_ready = 1'b0;
        me_flush       = 1'b1;
        #1;
        n_total++;
        if (stall_req !== 1'b1)
            $display("FAIL fl_rsp_stall: got %b want 1", stall_req);
        else n_pass++;
        cycle();
        me_flush       = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        n_total++;
        if (stall_req !== 1'b1)
            $display("FAIL fl_killed_stall: got %b want 1", stall_req);
        else n_pass++;
        cycle();
        dmem_rsp_valid = 1'b0;
        me_alu_result  = 64'h8000_3010;
        dmem_req_ready = 1'b1;
        #1;
        n_total++;
        if ({stall_req, dmem_req_valid} !== 2'b10)
            $display("FAIL fl_back_idle: got stall=%b req=%b want 1 0", stall_req, dmem_req_valid);
        else n_pass++;
        cycle();
        n_total++;
        if ({dmem_req_valid, dmem_addr} !== {1'b1, 64'h8000_3010})
            $display("FAIL fl_fresh_req: got req=%b addr=%h want 1 80003010",
                     dmem_req_valid, dmem_addr);
        else n_pass++;
        cycle();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 64'h5555_6666_7777_8888;
        cycle();
        dmem_rsp_valid = 1'b0;
        n_total++;
        if ({stall_req, me_mem_data} !== {1'b0, 64'h5555_6666_7777_8888})
            $display("FAIL fl_fresh_done: got stall=%b data=%h want 0 5555666677778888",
                     stall_req, me_mem_data);
        else n_pass++;
        me_advance  = 1'b1;
        me_mem_read = 1'b0;
        cycle();
        me_advance = 1'b0;
    endtask

    task automatic test_timeout();
        int rsp_cycles;
        int err_cnt;
        bit done;
        rsp_cycles = 0;
        err_cnt    = 0;
        done       = 1'b0;
        me_alu_result  = 64'h8000_4000;
        me_mem_size    = 2'd3;
        me_mem_read    = 1'b1;
        dmem_req_ready = 1'b1;
        cycle();
        cycle();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (bus_err) err_cnt++;
            if (stall_req && !dmem_req_valid) rsp_cycles++;
            else if (!stall_req) done = 1'b1;
            if (!done) cycle();
        end
        n_total++;
        if (!done)
            $display("FAIL to_bound: got no release after 400 cycles want release");
        else n_pass++;
        n_total++;
        if (rsp_cycles != 255)
            $display("FAIL to_rsp_cycles: got %0d want 255", rsp_cycles);
        else n_pass++;
        n_total++;
        if (me_mem_data !== 64'd0)
            $display("FAIL to_data: got %h want 0", me_mem_data);
        else n_pass++;
        cycle();
        if (bus_err) err_cnt++;
        n_total++;
        if (err_cnt != 1)
            $display("FAIL to_err_pulses: got %0d want 1", err_cnt);
        else n_pass++;
        me_advance  = 1'b1;
        me_mem_read = 1'b0;
        cycle();
        me_advance = 1'b0;
    endtask

    task automatic test_reset_in_req();
        me_alu_result  = 64'h8000_5000;
        me_mem_size    = 2'd3;
        me_mem_read    = 1'b1;
        dmem_req_ready = 1'b0;
        cycle();
        n_total++;
        if (dmem_req_valid !== 1'b1)
            $display("FAIL rr_in_req: got %b want 1", dmem_req_valid);
        else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_total++;
        if ({dmem_req_valid, stall_req} !== 2'b00)
            $display("FAIL rr_async: got req=%b stall=%b want 0 0", dmem_req_valid, stall_req);
        else n_pass++;
        me_mem_read = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        me_mem_read = 1'b1;
        #1;
        n_total++;
        if ({dmem_req_valid, stall_req} !== 2'b01)
            $display("FAIL rr_idle: got req=%b stall=%b want 0 1", dmem_req_valid, stall_req);
        else n_pass++;
        me_mem_read = 1'b0;
        cycle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_byte_enable();
        test_load_dword();
        test_store_byte();
        test_misalign();
        test_ready_hold();
        test_flush_rsp();
        test_timeout();
        test_reset_in_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
